// File: rtl/csr_commit_pkg.sv
// Shared types and constants for the WB-stage CSR commit unit and the CSR file.
// Holds the op classes, FSM state encoding, exception codes and op-class helpers.
package csr_commit_pkg;

  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_CSRRD   = 3'd1,
    OP_CSRWR   = 3'd2,
    OP_CSRXCHG = 3'd3,
    OP_ERTN    = 3'd4,
    OP_RDCNTVL = 3'd5,
    OP_RDCNTVH = 3'd6,
    OP_RDCNTID = 3'd7
  } op_e;

  typedef logic [0:0] state_e;
  localparam state_e ST_IDLE  = 1'b0;
  localparam state_e ST_REDIR = 1'b1;

  // Exception codes, shared with the CSR file's ESTAT encoding
  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;
  localparam logic [5:0] ECODE_IPE  = 6'h0E;
  localparam logic [5:0] ECODE_FPD  = 6'h0F;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
  localparam logic [8:0] ESUBCODE_ADEM = 9'h001;

  function automatic logic op_reads_csr(input op_e op);
    return (op == OP_CSRRD) || (op == OP_CSRWR) || (op == OP_CSRXCHG) || (op == OP_RDCNTID);
  endfunction

  function automatic logic op_writes_csr(input op_e op);
    return (op == OP_CSRWR) || (op == OP_CSRXCHG);
  endfunction

  function automatic logic op_writes_rf(input op_e op);
    return op_reads_csr(op) || (op == OP_RDCNTVL) || (op == OP_RDCNTVH);
  endfunction

endpackage

// File: rtl/wb_csr_commit_stable_counter.sv
// Free-running stable counter read by rdcntvl/rdcntvh; wraps from all-ones to zero.
module stable_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/wb_csr_commit.sv
// WB-stage CSR commit unit: drives the CSR file port, regfile writeback, flush and fetch redirect.
// Optional feature macro CSR_CNT_EN adds the 64-bit stable counter for rdcntvl/rdcntvh.
module wb_csr_commit
  import csr_commit_pkg::*;
#(
  parameter int          CNT_W   = 64,
  parameter logic [13:0] TID_NUM = 14'h40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [2:0]  in_op,
  input  logic [13:0] in_csr_num,
  input  logic [31:0] in_rj_val,
  input  logic [31:0] in_rd_val,
  input  logic        in_ex,
  input  logic [5:0]  in_ecode,
  input  logic [8:0]  in_esubcode,
  input  logic [31:0] in_vaddr,
  output logic        csr_re,
  output logic [13:0] csr_num,
  input  logic [31:0] csr_rvalue,
  output logic        csr_we,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vaddr,
  output logic        ertn_flush,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ertn_pc,
  output logic        rf_we,
  output logic [31:0] rf_wdata,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  op_e         op;
  state_e      state;
  logic        fire;
  logic        is_ex;
  logic        commit_ok;
  logic        redirecting;
  logic [31:0] redirect_pc_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0] cnt_lo;
  logic [31:0] cnt_hi;

  assign op = op_e'(in_op);

`ifdef CSR_CNT_EN
  stable_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .cnt (cnt)
  );
`else
  assign cnt = '0;
`endif

  assign cnt_lo = cnt[31:0];
  assign cnt_hi = cnt[63:32];

  // Commit stage: everything below is combinational from in_* in the fire cycle
  assign in_ready  = (state == ST_IDLE);
  assign fire      = in_valid & in_ready & ~rst;
  assign is_ex     = fire & in_ex;
  assign commit_ok = fire & ~in_ex;

  assign csr_re     = commit_ok & op_reads_csr(op);
  assign csr_num    = fire ? ((op == OP_RDCNTID) ? TID_NUM : in_csr_num) : 14'd0;
  assign csr_we     = commit_ok & op_writes_csr(op);
  assign csr_wvalue = csr_we ? in_rd_val : 32'd0;

  always_comb begin
    csr_wmask = 32'd0;
    if (csr_we) csr_wmask = (op == OP_CSRXCHG) ? in_rj_val : 32'hFFFF_FFFF;
  end

  assign wb_ex       = is_ex;
  assign wb_ecode    = is_ex ? in_ecode    : 6'd0;
  assign wb_esubcode = is_ex ? in_esubcode : 9'd0;
  assign wb_pc       = is_ex ? in_pc       : 32'd0;
  assign wb_vaddr    = is_ex ? in_vaddr    : 32'd0;

  assign ertn_flush = commit_ok & (op == OP_ERTN);
  assign rf_we      = commit_ok & op_writes_rf(op);

  always_comb begin
    rf_wdata = 32'd0;
    if (rf_we) begin
      case (op)
        OP_RDCNTVL: rf_wdata = cnt_lo;
        OP_RDCNTVH: rf_wdata = cnt_hi;
        default:    rf_wdata = csr_rvalue;
      endcase
    end
  end

  // CSR writes refetch so a new IE/LIE value governs the next instruction
  assign redirecting = is_ex | ertn_flush | csr_we;

  always_comb begin
    redirect_pc_nxt = in_pc + 32'd4;
    if (is_ex)           redirect_pc_nxt = ex_entry;
    else if (ertn_flush) redirect_pc_nxt = ertn_pc;
  end

  assign flush          = (state == ST_REDIR) | redirecting;
  assign redirect_valid = (state == ST_REDIR);

  // Redirect stage: target held until fetch accepts it
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      redirect_pc <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (redirecting) begin
            state       <= ST_REDIR;
            redirect_pc <= redirect_pc_nxt;
          end
        end
        default: begin
          if (redirect_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_csr_commit.sv
// Directed bench for wb_csr_commit: CSR ops, exception/ertn redirects, handshake stalls, reset in REDIR.
module tb_wb_csr_commit;
  import csr_commit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [2:0]  in_op;
  logic [13:0] in_csr_num;
  logic [31:0] in_rj_val;
  logic [31:0] in_rd_val;
  logic        in_ex;
  logic [5:0]  in_ecode;
  logic [8:0]  in_esubcode;
  logic [31:0] in_vaddr;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        ertn_flush;
  logic [31:0] ex_entry;
  logic [31:0] ertn_pc;
  logic        rf_we;
  logic [31:0] rf_wdata;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_csr_commit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_op(in_op), .in_csr_num(in_csr_num), .in_rj_val(in_rj_val), .in_rd_val(in_rd_val),
    .in_ex(in_ex), .in_ecode(in_ecode), .in_esubcode(in_esubcode), .in_vaddr(in_vaddr),
    .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue), .csr_we(csr_we),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
    .ex_entry(ex_entry), .ertn_pc(ertn_pc), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0; in_pc = '0; in_op = OP_NONE; in_csr_num = '0; in_rj_val = '0;
    in_rd_val = '0; in_ex = 1'b0; in_ecode = '0; in_esubcode = '0; in_vaddr = '0;
    csr_rvalue = '0; ex_entry = '0; ertn_pc = '0; redirect_ready = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Strobes stay low while reset is held, even with a valid csrwr presented
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_CSRWR; in_rd_val = 32'h0000_DEAD; #1;
    chk("rst_csr_we", csr_we, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);
    clear_inputs();
    rst = 1'b0;

    // csrxchg returns the pre-write value and refetches at pc+4
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_CSRXCHG; in_pc = 32'h1C00_0000; in_csr_num = 14'h4;
    in_rj_val = 32'h0000_0004; in_rd_val = 32'hFFFF_FFFF; csr_rvalue = 32'h0; #1;
    chk("xchg_csr_we", csr_we, 1);
    chk("xchg_csr_re", csr_re, 1);
    chk("xchg_csr_num", csr_num, 14'h4);
    chk("xchg_wmask", csr_wmask, 32'h4);
    chk("xchg_wvalue", csr_wvalue, 32'hFFFF_FFFF);
    chk("xchg_rf_we", rf_we, 1);
    chk("xchg_rf_wdata", rf_wdata, 32'h0);
    chk("xchg_flush", flush, 1);
    @(posedge clk); #1;
    chk("xchg_redirect_valid", redirect_valid, 1);
    chk("xchg_redirect_pc", redirect_pc, 32'h1C00_0004);
    chk("xchg_in_ready", in_ready, 0);
    chk("xchg_redir_no_we", csr_we, 0);
    chk("xchg_redir_no_rfwe", rf_we, 0);
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    chk("xchg_back_idle", in_ready, 1);
    chk("xchg_redirect_drop", redirect_valid, 0);
    clear_inputs();

    // Exception overrides the op and enters the handler
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_CSRWR; in_ex = 1'b1; in_ecode = ECODE_SYS;
    in_esubcode = 9'h0; in_pc = 32'h1C00_0100; in_vaddr = 32'h0000_1234;
    ex_entry = 32'h1C00_8000; #1;
    chk("ex_wb_ex", wb_ex, 1);
    chk("ex_wb_ecode", wb_ecode, 6'h0B);
    chk("ex_wb_pc", wb_pc, 32'h1C00_0100);
    chk("ex_wb_vaddr", wb_vaddr, 32'h0000_1234);
    chk("ex_csr_we", csr_we, 0);
    chk("ex_csr_re", csr_re, 0);
    chk("ex_rf_we", rf_we, 0);
    chk("ex_ertn", ertn_flush, 0);
    chk("ex_flush", flush, 1);
    @(posedge clk); #1;
    chk("ex_redirect_pc", redirect_pc, 32'h1C00_8000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ex_hold_in_ready", in_ready, 0);
      chk("ex_hold_flush", flush, 1);
      chk("ex_hold_wb_ex", wb_ex, 0);
      chk("ex_hold_redirect_valid", redirect_valid, 1);
    end
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    chk("ex_back_idle", in_ready, 1);
    clear_inputs();

    // ertn
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_ERTN; in_pc = 32'h1C00_8010; ertn_pc = 32'h1C00_0104; #1;
    chk("ertn_flush_pulse", ertn_flush, 1);
    chk("ertn_rf_we", rf_we, 0);
    chk("ertn_csr_we", csr_we, 0);
    @(posedge clk); #1;
    chk("ertn_flush_drop", ertn_flush, 0);
    chk("ertn_redirect_pc", redirect_pc, 32'h1C00_0104);
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    clear_inputs();

    // csrrd back-to-back for four cycles
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = OP_CSRRD; in_csr_num = 14'h5;
      csr_rvalue = 32'hA5A5_0000 + 32'(i); #1;
      chk("rd_in_ready", in_ready, 1);
      chk("rd_flush", flush, 0);
      chk("rd_rf_wdata", rf_wdata, 32'hA5A5_0000 + 32'(i));
      chk("rd_csr_we", csr_we, 0);
    end

    // rdcntid reads the TID CSR
    @(negedge clk);
    in_op = OP_RDCNTID; in_csr_num = 14'h3FF; csr_rvalue = 32'h0000_0077; #1;
    chk("tid_csr_num", csr_num, 14'h40);
    chk("tid_csr_re", csr_re, 1);
    chk("tid_rf_wdata", rf_wdata, 32'h77);

    // NONE commits nothing
    @(negedge clk);
    in_op = OP_NONE; #1;
    chk("none_rf_we", rf_we, 0);
    chk("none_csr_re", csr_re, 0);
    chk("none_flush", flush, 0);

`ifndef CSR_CNT_EN
    @(negedge clk);
    in_op = OP_RDCNTVL; #1;
    chk("cntvl_rf_we", rf_we, 1);
    chk("cntvl_zero", rf_wdata, 0);
    @(negedge clk);
    in_op = OP_RDCNTVH; #1;
    chk("cntvh_rf_we", rf_we, 1);
    chk("cntvh_zero", rf_wdata, 0);
`endif

    // Reset while waiting for redirect_ready
    @(negedge clk);
    in_op = OP_CSRWR; in_pc = 32'h1C00_0200; #1;
    @(posedge clk); #1;
    chk("rstredir_pre", redirect_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstredir_valid", redirect_valid, 0);
    chk("rstredir_flush", flush, 0);
    chk("rstredir_in_ready", in_ready, 1);
    chk("rstredir_pc", redirect_pc, 0);
    clear_inputs();
    rst = 1'b0;

`ifdef CSR_CNT_EN
    // Reset edge loaded 0; ten further edges give 10
    repeat (10) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_RDCNTVL; #1;
    chk("cntvl_10", rf_wdata, 32'd10);
    in_valid = 1'b0;
    force dut.u_cnt.cnt = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.u_cnt.cnt;
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_RDCNTVH; #1;
    chk("cntvh_carry", rf_wdata, 32'd1);
    clear_inputs();
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
